truth_table_bist: RTL and testbench
===================================

TRUTH_TABLE_BIST -- requirements
Module: truth_table_bist

Interface
REQ-001 Parameter EXPECTED, 16'h77FF: expected DUT output per vector; bit i is the expected output for vector i.
REQ-002 Parameter SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port start  input  1  single-cycle request to run a full sweep.
REQ-006 Port abort  input  1  terminates a running sweep.
REQ-007 Port dut_in  output  4  vector driven to the DUT; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-008 Port dut_out  input  1  DUT response; treated as synchronous to clk.
REQ-009 Port busy  output  1  high while a sweep is in progress.
REQ-010 Port done  output  1  high while results are valid.
REQ-011 Port pass  output  1  done and err_count==0.
REQ-012 Port err_count  output  5  mismatch count, 0..16.
REQ-013 Port first_fail_vec  output  4  lowest vector that mismatched.
REQ-014 Port first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-015 The state machine SHALL have four states: IDLE, SETTLE, COMPARE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear err_count, first_fail_valid and first_fail_vec, set dut_in=0, and enter SETTLE.
REQ-017 SETTLE SHALL hold dut_in constant for exactly SETTLE_CYCLES cycles, then enter COMPARE.
REQ-018 COMPARE SHALL last one cycle and SHALL compare dut_out with EXPECTED[dut_in].
REQ-019 On a COMPARE mismatch, err_count SHALL increment by 1 and SHALL never wrap; 16 is the maximum.
REQ-020 On the first mismatch of a sweep, dut_in SHALL be captured into first_fail_vec and first_fail_valid SHALL be set; later mismatches SHALL leave both unchanged.
REQ-021 When COMPARE ends with dut_in<15, dut_in SHALL increment and the block SHALL enter SETTLE.
REQ-022 When COMPARE ends with dut_in==15, the block SHALL enter DONE; dut_in SHALL NOT wrap during a sweep.
REQ-023 Latency: done SHALL rise exactly 16*(SETTLE_CYCLES+1) clock edges after the edge that samples start (48 edges at the default).
REQ-024 busy SHALL be 1 exactly in SETTLE and COMPARE.
REQ-025 done SHALL be 1 exactly in DONE.
REQ-026 pass SHALL equal done AND (err_count==0).
REQ-027 In DONE, err_count, first_fail_vec, first_fail_valid and dut_in SHALL hold until the next start or reset.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort while busy SHALL return the block to IDLE on the next edge with dut_in=0 and the result outputs cleared.
REQ-030 abort and start asserted in the same cycle: abort SHALL win and no sweep SHALL start.
REQ-031 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE, with dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0 and the settle counter=0.
REQ-033 Reset asserted mid-sweep SHALL discard all partial results; start is not honoured in a cycle where rst_n=0.

Structure
REQ-034 A shared package truth_table_bist_pkg SHALL hold the state enum and the constants VEC_W=4, NUM_VEC=16 and CNT_W=5.
REQ-035 The settle timing SHALL be a sub-module, truth_table_bist_settle_timer (inputs: load, enable; output: expired), instantiated once.
REQ-036 All outputs SHALL be driven directly from registers.

Verification
REQ-037 Golden DUT connected, default parameters, start pulse -> done rises on edge 48; err_count=0, pass=1, first_fail_valid=0.
REQ-038 dut_out tied to 1 -> err_count=2, first_fail_vec=11, first_fail_valid=1, pass=0.
REQ-039 dut_out tied to 0 -> err_count=14, first_fail_vec=0, pass=0.
REQ-040 abort on edge 20 of a sweep -> next edge IDLE, busy=0, done=0, dut_in=0; a new start then completes with the normal results.
REQ-041 start re-pulsed while busy -> no effect, done still on edge 48; start in DONE -> results cleared, new sweep runs.
REQ-042 rst_n=0 during vector 7 -> all outputs at reset values on the next edge; SETTLE_CYCLES=1 sweep -> done on edge 32.

Source files
------------

// File: rtl/truth_table_bist_pkg.sv
// Shared types and constants for the truth-table BIST.
//   state_t : sweep controller states
//   VEC_W   : width of the vector driven to the DUT
//   NUM_VEC : number of vectors in one sweep (2**VEC_W)
//   CNT_W   : mismatch counter width (must hold NUM_VEC)
package truth_table_bist_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(NUM_VEC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_bist_settle_timer.sv
// Settle timer: counts the cycles a vector is held before it is sampled.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : restart the count for a new vector (first settle cycle follows)
//   enable     : high while the controller is in SETTLE
//   expired    : current SETTLE cycle is the last one
module truth_table_bist_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  // Loaded with SETTLE_CYCLES-1 so that expiry lands on the final settle
  // cycle; the controller then moves to COMPARE on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n)                   cnt <= '0;
    else if (load)                cnt <= 4'(SETTLE_CYCLES - 1);
    else if (enable && cnt != '0) cnt <= cnt - 4'd1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_bist.sv
// Truth-table BIST: sweeps all 16 input vectors into a 4-input DUT, holds each
// for SETTLE_CYCLES cycles, compares the response against EXPECTED and reports
// mismatch count and lowest failing vector.
//   clk, rst_n       : clock, synchronous active-low reset
//   start, abort     : run a sweep / terminate a running sweep (abort wins)
//   dut_in           : vector to DUT (bit0=a .. bit3=d)
//   dut_out          : DUT response, synchronous to clk
//   busy, done, pass : status; pass = done && err_count==0
//   err_count        : mismatches, saturates at 16
//   first_fail_vec   : lowest mismatching vector, qualified by first_fail_valid
module truth_table_bist
  import truth_table_bist_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECTED      = 16'h77FF,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  state_t           state, state_n;
  logic [VEC_W-1:0] dut_in_n, ffv_n;
  logic [CNT_W-1:0] err_n;
  logic             ffval_n;
  logic             load, expired, mismatch;

  truth_table_bist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .enable (state == SETTLE),
    .expired(expired)
  );

  always_comb begin
    state_n  = state;
    dut_in_n = dut_in;
    err_n    = err_count;
    ffv_n    = first_fail_vec;
    ffval_n  = first_fail_valid;
    load     = 1'b0;
    mismatch = 1'b0;
    case (state)
      IDLE, DONE: begin
        // abort+start together: abort wins, nothing starts
        if (start && !abort) begin
          state_n  = SETTLE;
          dut_in_n = '0;
          err_n    = '0;
          ffv_n    = '0;
          ffval_n  = 1'b0;
          load     = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n  = IDLE;
          dut_in_n = '0;
          err_n    = '0;
          ffv_n    = '0;
          ffval_n  = 1'b0;
        end else if (expired) begin
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (abort) begin
          state_n  = IDLE;
          dut_in_n = '0;
          err_n    = '0;
          ffv_n    = '0;
          ffval_n  = 1'b0;
        end else begin
          mismatch = (dut_out != EXPECTED[dut_in]);
          if (mismatch) begin
            if (err_count != ERR_MAX) err_n = err_count + CNT_W'(1);
            // vectors run in ascending order, so the first miss is the lowest
            if (!first_fail_valid) begin
              ffv_n   = dut_in;
              ffval_n = 1'b1;
            end
          end
          if (dut_in == LAST_VEC) begin
            state_n = DONE;
          end else begin
            dut_in_n = dut_in + VEC_W'(1);
            state_n  = SETTLE;
            load     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status flags are computed from next-state values so every output is a
  // plain register yet lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      dut_in           <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state            <= state_n;
      dut_in           <= dut_in_n;
      err_count        <= err_n;
      first_fail_vec   <= ffv_n;
      first_fail_valid <= ffval_n;
      busy             <= (state_n == SETTLE) || (state_n == COMPARE);
      done             <= (state_n == DONE);
      pass             <= (state_n == DONE) && (err_n == '0);
    end
  end

endmodule

// File: tb/tb_truth_table_bist.sv
module tb_truth_table_bist;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dut_out;
  logic [3:0] dut_in, first_fail_vec;
  logic       busy, done, pass, first_fail_valid;
  logic [4:0] err_count;

  logic       start1 = 1'b0, dut_out1;
  logic [3:0] dut_in1, ffv1;
  logic       busy1, done1, pass1, ffval1;
  logic [4:0] err1;

  int mode = 0;  // 0 golden, 1 tied high, 2 tied low
  int cyc = 0;
  int checks = 0, failures = 0;

  typedef struct {int err; int ffv; int ffval; int pass; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // golden function for 16'h77FF: y = ~(a & b & d)
  always_comb begin
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = 1'b0;
      default: dut_out = ~(dut_in[0] & dut_in[1] & dut_in[3]);
    endcase
    dut_out1 = ~(dut_in1[0] & dut_in1[1] & dut_in1[3]);
  end

  truth_table_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  truth_table_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .dut_in(dut_in1),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor: every rising edge of done pops one expected result
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", err_count, e.err);
        chk("first_fail_vec", first_fail_vec, e.ffv);
        chk("first_fail_valid", first_fail_valid, e.ffval);
        chk("pass", pass, e.pass);
        chk("busy_in_done", busy, 0);
      end
    end
    done_prev = done;
  end

  task automatic pulse_start(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_fail_vec"}, first_fail_vec, 0);
    chk({tag, "_first_fail_valid"}, first_fail_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, i;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // golden sweep: done 48 edges after the start edge
    mode = 0;
    pulse_start(t);
    q.push_back('{0, 0, 0, 1, t + 1 + 48});
    drain();
    chk("done_hold_dut_in", dut_in, 15);

    // abort in DONE has no effect
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_done_done", done, 1);
    chk("abort_done_pass", pass, 1);
    chk("abort_done_dut_in", dut_in, 15);

    // dut_out tied high: vectors 11 and 15 miss
    mode = 1;
    pulse_start(t);
    q.push_back('{2, 11, 1, 0, t + 1 + 48});
    drain();

    // dut_out tied low; start from DONE must clear previous results
    mode = 2;
    pulse_start(t);
    chk("restart_err_cleared", err_count, 0);
    chk("restart_ffvalid_cleared", first_fail_valid, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    q.push_back('{14, 0, 1, 0, t + 1 + 48});
    drain();

    // start re-pulsed while busy is ignored
    mode = 0;
    pulse_start(t);
    q.push_back('{0, 0, 0, 1, t + 1 + 48});
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    drain();

    // abort on edge 20 of a sweep with errors accumulated
    mode = 2;
    pulse_start(t);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk_reset_vals("abort");

    // abort and start together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    chk("abort_start_busy_later", busy, 0);

    // fresh start after abort completes normally
    mode = 0;
    pulse_start(t);
    q.push_back('{0, 0, 0, 1, t + 1 + 48});
    drain();

    // reset during vector 7, with start held in the reset cycle
    mode = 2;
    pulse_start(t);
    for (i = 0; i < 100 && dut_in !== 4'd7; i++) @(negedge clk);
    chk("reached_vec7", dut_in, 7);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", busy, 0);

    // SETTLE_CYCLES=1 instance: done 32 edges after start
    @(negedge clk);
    start1 = 1'b1;
    t = cyc;
    @(negedge clk);
    start1 = 1'b0;
    for (i = 0; i < 100 && done1 !== 1'b1; i++) @(negedge clk);
    chk("s1_done", done1, 1);
    chk("s1_done_cycle", cyc, t + 1 + 32);
    chk("s1_pass", pass1, 1);
    chk("s1_err_count", err1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
